// File: rtl/paddle_tracker.sv
// AI paddle controller: steps the paddle toward the ball once per frame tick
// with reaction delay, dead zone, speed ramp and playfield saturation.
module paddle_tracker #(
  parameter int COORD_W      = 16,
  parameter int HALF_PADDLE  = 50,
  parameter int MAX_SPEED    = 8,
  parameter int ACCEL_PERIOD = 4,
  parameter int DEAD_ZONE    = 4,
  parameter int REACT_DELAY  = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_tick,
  input  logic                           enable,
  input  logic [2*COORD_W-1:0]           dimensions,
  input  logic [2*COORD_W-1:0]           ball_position,
  input  logic [COORD_W-1:0]             paddle_x,
  output logic [2*COORD_W-1:0]           paddle_position,
  output logic                           moving,
  output logic                           direction,
  output logic [$clog2(MAX_SPEED+1)-1:0] speed
);

  localparam int W1 = COORD_W + 1;
  localparam int SW = $clog2(MAX_SPEED + 1);
  localparam int AW = $clog2(ACCEL_PERIOD + 1);
  localparam int DW = (REACT_DELAY > 0) ? $clog2(REACT_DELAY + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_TRACK
  } state_e;

  state_e            state_q, state_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [COORD_W-1:0] px_q;
  logic [SW-1:0]     spd_q, spd_d;
  logic              dir_q, dir_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic [AW-1:0]     acc_q, acc_d;

  logic [W1-1:0] h_w, half_h, rst_y, ymax;
  logic [W1-1:0] y_w, by_w, center, err_u;
  logic [W1-1:0] abs_err, step_w, sum_w, dif_w, cand;
  logic [AW-1:0] acc_nxt;
  logic [SW-1:0] spd_up;
  logic          err_pos, out_dz;
  logic          unused_hi;

  assign unused_hi = ^{dimensions[2*COORD_W-1:COORD_W],
                       ball_position[2*COORD_W-1:COORD_W]};

  assign h_w    = {1'b0, dimensions[COORD_W-1:0]};
  assign half_h = h_w >> 1;
  assign rst_y  = (half_h < W1'(HALF_PADDLE)) ? '0
                : half_h - W1'(HALF_PADDLE);
  assign ymax   = (h_w < W1'(2*HALF_PADDLE)) ? '0
                : h_w - W1'(2*HALF_PADDLE);

  assign y_w     = {1'b0, y_q};
  assign by_w    = {1'b0, ball_position[COORD_W-1:0]};
  assign center  = y_w + W1'(HALF_PADDLE);
  assign err_u   = by_w - center;
  assign err_pos = !err_u[W1-1] && (err_u != '0);
  assign abs_err = err_u[W1-1] ? -err_u : err_u;
  assign out_dz  = abs_err > W1'(DEAD_ZONE);

  assign step_w = (W1'(spd_q) < abs_err) ? W1'(spd_q) : abs_err;
  assign sum_w  = y_w + step_w;
  assign dif_w  = (y_w >= step_w) ? y_w - step_w : '0;

  // Both directions clamp to ymax so a shrunken playfield pulls y back in
  always_comb begin
    cand = dir_q ? sum_w : dif_w;
    if (cand > ymax) cand = ymax;
  end

  assign acc_nxt = acc_q + AW'(1);
  assign spd_up  = (spd_q < SW'(MAX_SPEED)) ? spd_q + SW'(1) : spd_q;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    spd_d   = spd_q;
    dir_d   = dir_q;
    dly_d   = dly_q;
    acc_d   = acc_q;
    if (!enable) begin
      state_d = S_IDLE;
      spd_d   = '0;
      dly_d   = '0;
      acc_d   = '0;
    end else if (frame_tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (out_dz) begin
            if (REACT_DELAY == 0) begin
              state_d = S_TRACK;
              spd_d   = SW'(1);
              dir_d   = err_pos;
            end else begin
              state_d = S_WAIT;
              dly_d   = DW'(REACT_DELAY);
            end
          end
        end
        S_WAIT: begin
          if (!out_dz) begin
            state_d = S_IDLE;
          end else if (dly_q == DW'(1)) begin
            state_d = S_TRACK;
            spd_d   = SW'(1);
            dir_d   = err_pos;
          end else begin
            dly_d = dly_q - DW'(1);
          end
        end
        S_TRACK: begin
          if (!out_dz) begin
            state_d = S_IDLE;
            spd_d   = '0;
          end else if (err_pos != dir_q) begin
            dir_d = err_pos;
            spd_d = SW'(1);
            acc_d = '0;
          end else begin
            y_d = cand[COORD_W-1:0];
            if (acc_nxt == AW'(ACCEL_PERIOD)) begin
              acc_d = '0;
              spd_d = spd_up;
            end else begin
              acc_d = acc_nxt;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    px_q <= paddle_x;
    if (!rst) begin
      state_q <= S_IDLE;
      y_q     <= rst_y[COORD_W-1:0];
      spd_q   <= '0;
      dir_q   <= 1'b0;
      dly_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      spd_q   <= spd_d;
      dir_q   <= dir_d;
      dly_q   <= dly_d;
      acc_q   <= acc_d;
    end
  end

  assign paddle_position = {px_q, y_q};
  assign moving          = (state_q == S_TRACK);
  assign direction       = dir_q;
  assign speed           = spd_q;

endmodule

// File: tb/tb_paddle_tracker.sv
// Bench for paddle_tracker: integer reference model checked every cycle,
// plus directed literal expectations from the pong test plan.
module tb_paddle_tracker;

  localparam int HP = 50;
  localparam int MS = 8;
  localparam int AP = 4;
  localparam int DZ = 4;
  localparam int RD = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        enable;
  logic [31:0] dimensions;
  logic [31:0] ball_position;
  logic [15:0] paddle_x;
  logic [31:0] paddle_position;
  logic        moving;
  logic        direction;
  logic [3:0]  speed;

  always #5 clk = ~clk;

  paddle_tracker dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .enable          (enable),
    .dimensions      (dimensions),
    .ball_position   (ball_position),
    .paddle_x        (paddle_x),
    .paddle_position (paddle_position),
    .moving          (moving),
    .direction       (direction),
    .speed           (speed)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // mode: 0 idle, 1 reacting, 2 tracking
  int m_y, m_mode, m_spd, m_dir, m_dly, m_acc, m_x;
  bit m_valid = 1'b0;

  task automatic model_edge();
    int h, by, err, ae, ymax, step, ny;
    h    = int'(dimensions[15:0]);
    by   = int'(ball_position[15:0]);
    m_x  = int'(paddle_x);
    err  = by - (m_y + HP);
    ae   = (err < 0) ? -err : err;
    ymax = (h < 2*HP) ? 0 : h - 2*HP;
    if (!rst) begin
      m_y     = (h/2 < HP) ? 0 : h/2 - HP;
      m_mode  = 0;
      m_spd   = 0;
      m_dir   = 0;
      m_dly   = 0;
      m_acc   = 0;
      m_valid = 1'b1;
    end else if (!enable) begin
      m_mode = 0;
      m_spd  = 0;
      m_dly  = 0;
      m_acc  = 0;
    end else if (frame_tick) begin
      if (m_mode == 0) begin
        if (ae > DZ) begin
          if (RD == 0) begin
            m_mode = 2; m_spd = 1; m_dir = (err > 0);
          end else begin
            m_mode = 1; m_dly = RD;
          end
        end
      end else if (m_mode == 1) begin
        if (ae <= DZ) m_mode = 0;
        else if (m_dly == 1) begin
          m_mode = 2; m_spd = 1; m_dir = (err > 0);
        end else m_dly = m_dly - 1;
      end else begin
        if (ae <= DZ) begin
          m_mode = 0; m_spd = 0;
        end else if (int'(err > 0) != m_dir) begin
          m_dir = 1 - m_dir; m_spd = 1; m_acc = 0;
        end else begin
          step = (m_spd < ae) ? m_spd : ae;
          ny   = (m_dir != 0) ? m_y + step : m_y - step;
          if (ny < 0) ny = 0;
          if (ny > ymax) ny = ymax;
          m_y   = ny;
          m_acc = m_acc + 1;
          if (m_acc == AP) begin
            m_acc = 0;
            if (m_spd < MS) m_spd = m_spd + 1;
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      n_tests++;
      if (paddle_position !== {m_x[15:0], m_y[15:0]} ||
          moving !== (m_mode == 2) ||
          direction !== m_dir[0] ||
          speed !== m_spd[3:0]) begin
        n_fail++;
        $display("FAIL model t=%0t pos=%h mv=%b dir=%b spd=%0d want pos=%h mv=%0d dir=%0d spd=%0d",
                 $time, paddle_position, moving, direction, speed,
                 {m_x[15:0], m_y[15:0]}, (m_mode == 2), m_dir, m_spd);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic tk);
    frame_tick = tk;
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic set_ball(input int y);
    ball_position = {16'd320, y[15:0]};
  endtask

  initial begin
    rst        = 1'b0;
    enable     = 1'b1;
    frame_tick = 1'b0;
    dimensions = 32'h028001E0;
    paddle_x   = 16'd600;
    set_ball(240);
    @(negedge clk);

    cyc(0); cyc(0);
    chk("rst_pos", int'(paddle_position), int'({16'd600, 16'd190}));
    chk("rst_speed", int'(speed), 0);
    chk("rst_moving", int'(moving), 0);
    dimensions = {16'd640, 16'd80};
    cyc(0);
    chk("rst_h80_y", int'(paddle_position[15:0]), 0);
    dimensions = 32'h028001E0;
    cyc(0);
    chk("rst_h480_y", int'(paddle_position[15:0]), 190);

    rst = 1'b1;
    set_ball(243);
    repeat (20) cyc(1);
    chk("dz_hold_y", int'(paddle_position[15:0]), 190);
    chk("dz_hold_mv", int'(moving), 0);
    set_ball(245);
    cyc(1);
    chk("dz_wait_mv", int'(moving), 0);
    repeat (3) cyc(1);
    chk("dz_track_mv", int'(moving), 1);

    rst = 1'b0;
    cyc(0);
    rst = 1'b1;
    set_ball(400);
    cyc(1);
    chk("ramp_t1_mv", int'(moving), 0);
    cyc(1); cyc(1);
    chk("ramp_t3_mv", int'(moving), 0);
    cyc(1);
    chk("ramp_t4_mv", int'(moving), 1);
    chk("ramp_t4_spd", int'(speed), 1);
    chk("ramp_t4_dir", int'(direction), 1);
    chk("ramp_t4_y", int'(paddle_position[15:0]), 190);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("ramp_step_y", int'(paddle_position[15:0]), 191 + i);
    end
    chk("ramp_t8_spd", int'(speed), 2);
    cyc(1);
    chk("ramp_t9_y", int'(paddle_position[15:0]), 196);
    repeat (23) cyc(1);
    chk("ramp_t32_y", int'(paddle_position[15:0]), 302);
    chk("ramp_t32_spd", int'(speed), 8);
    repeat (4) cyc(1);
    chk("ramp_t36_y", int'(paddle_position[15:0]), 334);
    chk("ramp_ceiling", int'(speed), 8);

    repeat (3) cyc(0);
    chk("notick_y", int'(paddle_position[15:0]), 334);
    chk("notick_mv", int'(moving), 1);

    set_ball(479);
    repeat (6) cyc(1);
    chk("sat_y", int'(paddle_position[15:0]), 380);
    repeat (3) cyc(1);
    chk("sat_hold_y", int'(paddle_position[15:0]), 380);
    chk("sat_mv", int'(moving), 1);

    set_ball(0);
    cyc(1);
    chk("rev_y", int'(paddle_position[15:0]), 380);
    chk("rev_dir", int'(direction), 0);
    chk("rev_spd", int'(speed), 1);
    chk("rev_mv", int'(moving), 1);
    cyc(1);
    chk("rev_step_y", int'(paddle_position[15:0]), 379);

    enable = 1'b0;
    cyc(0);
    chk("en_mv", int'(moving), 0);
    chk("en_spd", int'(speed), 0);
    chk("en_y", int'(paddle_position[15:0]), 379);
    enable = 1'b1;
    repeat (5) cyc(1);
    chk("retrack_y", int'(paddle_position[15:0]), 378);
    chk("retrack_mv", int'(moving), 1);
    rst = 1'b0;
    cyc(0);
    chk("midrst_y", int'(paddle_position[15:0]), 190);
    chk("midrst_mv", int'(moving), 0);
    rst = 1'b1;
    repeat (3) cyc(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
